// File: rtl/sysid_pkg.sv
// sysid_pkg: shared FSM states, default expected words and counter sizing for the sysid checker.
package sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE} state_t;
  localparam logic [31:0] DEFAULT_ID = 32'd0;
  localparam logic [31:0] DEFAULT_TIMESTAMP = 32'd1463423999;
  function automatic int stall_width(input int n);
    int w;
    w = $clog2(n + 1);
    return w < 8 ? 8 : w;
  endfunction
endpackage

// File: rtl/sysid_read_timer.sv
// sysid_read_timer: per-read stall and read-latency counters.
//   clock, reset_n : clock, async active-low reset
//   stall          : read pending and slave asserting waitrequest
//   wait_lat       : FSM is waiting out read latency
//   stall_hit      : this stalled cycle is the TIMEOUT_CYCLES-th one
//   lat_last       : this latency cycle is the one carrying valid readdata
module sysid_read_timer
  import sysid_pkg::*;
#(
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall,
  input  logic wait_lat,
  output logic stall_hit,
  output logic lat_last
);
  localparam int CW = stall_width(TIMEOUT_CYCLES);
  logic [CW-1:0] stall_cnt;
  logic [1:0] lat_cnt;
  // A read ends on its first non-stalled cycle, so clearing whenever not stalled also clears on entry.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stall_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      stall_cnt <= stall ? stall_cnt + CW'(1) : '0;
      lat_cnt <= wait_lat ? lat_cnt + 2'd1 : '0;
    end
  assign stall_hit = stall && stall_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign lat_last = wait_lat && lat_cnt == 2'(READ_LATENCY - 1);
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid ID and timestamp words over Avalon-MM and compares them with expected values.
//   clock, reset_n        : clock, async active-low reset
//   start                 : pulse to (re)run the check from IDLE or DONE
//   address, read         : Avalon-MM master request
//   waitrequest, readdata : Avalon-MM slave response
//   busy, done            : sequence running / sticky result valid
//   id_ok, ts_ok, timeout : compare results and stall-timeout flag
//   id_value, ts_value    : captured words
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_TIMESTAMP,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  localparam bit LAT0 = READ_LATENCY == 0;
  state_t state, next;
  logic auto_run, stall_hit, lat_last, cap_id, cap_ts;
  sysid_read_timer #(.READ_LATENCY(READ_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock(clock),
    .reset_n(reset_n),
    .stall(read && waitrequest),
    .wait_lat(state == LAT_ID || state == LAT_TS),
    .stall_hit(stall_hit),
    .lat_last(lat_last)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = (auto_run || start) ? RD_ID : IDLE;
      RD_ID:   next = stall_hit ? DONE : waitrequest ? RD_ID : LAT0 ? RD_TS : LAT_ID;
      LAT_ID:  next = lat_last ? RD_TS : LAT_ID;
      RD_TS:   next = stall_hit ? DONE : waitrequest ? RD_TS : LAT0 ? CHECK : LAT_TS;
      LAT_TS:  next = lat_last ? CHECK : LAT_TS;
      CHECK:   next = DONE;
      DONE:    next = start ? RD_ID : DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    read = state == RD_ID || state == RD_TS;
    address = state == RD_TS;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  assign cap_id = LAT0 ? state == RD_ID && !waitrequest : state == LAT_ID && lat_last;
  assign cap_ts = LAT0 ? state == RD_TS && !waitrequest : state == LAT_TS && lat_last;
  // auto_run is set by reset so the first clock after deassertion launches a check unprompted.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      auto_run <= 1'b1;
      id_value <= '0;
      ts_value <= '0;
      id_ok <= 1'b0;
      ts_ok <= 1'b0;
      timeout <= 1'b0;
    end else begin
      auto_run <= 1'b0;
      if (cap_id) id_value <= readdata;
      if (cap_ts) ts_value <= readdata;
      if (state == DONE && start) begin
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
        timeout <= 1'b0;
      end
      if (state == CHECK) begin
        id_ok <= id_value == EXPECTED_ID;
        ts_ok <= ts_value == EXPECTED_TIMESTAMP;
      end
      if (stall_hit) begin
        timeout <= 1'b1;
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench for sysid_checker with zero-latency and two-cycle-latency slaves.
module tb_sysid_checker;
  localparam logic [31:0] TS = 32'd1463423999;
  typedef struct packed {
    logic id_ok;
    logic ts_ok;
    logic timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } res_t;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic address, read, waitrequest, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] readdata, id_value, ts_value;
  logic address2, read2, busy2, done2, id_ok2, ts_ok2, timeout2;
  logic [31:0] readdata2, id_value2, ts_value2;
  logic [31:0] id_word = 32'd0;
  logic [1:0] p1 = 2'b00, p2 = 2'b00;
  int wait_n = 0, sc = 0;
  int checks = 0, failures = 0;
  res_t exp_q[$];
  res_t got, exp;

  always #5 clock = ~clock;

  sysid_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start), .address(address), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .busy(busy), .done(done), .id_ok(id_ok),
    .ts_ok(ts_ok), .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );
  sysid_checker #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .address(address2), .read(read2),
    .waitrequest(1'b0), .readdata(readdata2), .busy(busy2), .done(done2), .id_ok(id_ok2),
    .ts_ok(ts_ok2), .timeout(timeout2), .id_value(id_value2), .ts_value(ts_value2)
  );

  // zero-latency slave: stalls wait_n cycles per read
  assign waitrequest = read && (sc < wait_n);
  assign readdata = address ? TS : id_word;
  always @(posedge clock) sc <= (read && waitrequest) ? sc + 1 : 0;

  // two-cycle-latency slave: garbage until the word is due
  always @(posedge clock) begin
    p1 <= {read2, address2};
    p2 <= p1;
  end
  assign readdata2 = p2[1] ? (p2[0] ? TS : 32'd0) : 32'hDEADBEEF;

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic run_to_done(input int bound, output int cyc);
    cyc = 0;
    while (!done && cyc < bound) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value});
    end
    checks++;
    if ({read2, busy2, done2, id_ok2, ts_ok2, timeout2, id_value2, ts_value2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs2 got=%h want=0", {read2, busy2, done2, id_ok2, ts_ok2, timeout2, id_value2, ts_value2});
    end
  endtask

  task automatic test_autorun();
    int cyc;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS});
    reset_n = 1'b1;
    run_to_done(20, cyc);
    checks++;
    if (!done || cyc != 4) begin
      failures++;
      $display("FAIL autorun_latency got done=%0b cycles=%0d want done=1 cycles=4", done, cyc);
    end
    got = {id_ok, ts_ok, timeout, id_value, ts_value};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL autorun_result got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_bad_id();
    int cyc;
    id_word = 32'd1;
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 32'd1, TS});
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || id_ok !== 1'b0 || ts_ok !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear got done=%b busy=%b id_ok=%b ts_ok=%b want 0 1 0 0", done, busy, id_ok, ts_ok);
    end
    run_to_done(20, cyc);
    checks++;
    if (!done || cyc != 3) begin
      failures++;
      $display("FAIL bad_id_latency got done=%0b cycles=%0d want done=1 cycles=3", done, cyc);
    end
    got = {id_ok, ts_ok, timeout, id_value, ts_value};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL bad_id_result got=%h want=%h", got, exp);
    end
    id_word = 32'd0;
  endtask

  task automatic test_stall();
    int cyc = 0, stalls = 0;
    logic prev = 1'b0, pa = 1'b0;
    wait_n = 3;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS});
    pulse_start();
    while (!done && cyc < 50) begin
      if (read && waitrequest) stalls++;
      if (prev) begin
        checks++;
        if (read !== 1'b1 || address !== pa) begin
          failures++;
          $display("FAIL stall_hold got read=%b addr=%b want read=1 addr=%b", read, address, pa);
        end
      end
      prev = read && waitrequest;
      pa = address;
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!done || cyc != 9 || stalls != 6) begin
      failures++;
      $display("FAIL stall_run got done=%0b cycles=%0d stalls=%0d want 1 9 6", done, cyc, stalls);
    end
    got = {id_ok, ts_ok, timeout, id_value, ts_value};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL stall_result got=%h want=%h", got, exp);
    end
    wait_n = 0;
  endtask

  task automatic test_timeout();
    int cyc = 0, stalls = 0;
    wait_n = 100000;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'd0, TS});
    pulse_start();
    while (!done && cyc < 400) begin
      if (read && waitrequest) stalls++;
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!done || stalls != 255 || read !== 1'b0 || busy !== 1'b0 || address !== 1'b0) begin
      failures++;
      $display("FAIL timeout_run got done=%0b stalls=%0d read=%b busy=%b addr=%b want 1 255 0 0 0", done, stalls, read, busy, address);
    end
    got = {id_ok, ts_ok, timeout, id_value, ts_value};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL timeout_result got=%h want=%h", got, exp);
    end
    wait_n = 0;
    pulse_start();
    checks++;
    if (timeout !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got timeout=%b done=%b want 0 0", timeout, done);
    end
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS});
    run_to_done(20, cyc);
    got = {id_ok, ts_ok, timeout, id_value, ts_value};
    exp = exp_q.pop_front();
    checks++;
    if (!done || got !== exp) begin
      failures++;
      $display("FAIL after_timeout got done=%0b res=%h want done=1 res=%h", done, got, exp);
    end
  endtask

  task automatic test_latency2();
    int cyc = 0, reads = 0;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS});
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    while (!done2 && cyc < 30) begin
      if (read2) reads++;
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!done2 || cyc != 7 || reads != 2) begin
      failures++;
      $display("FAIL lat2_run got done=%0b cycles=%0d reads=%0d want 1 7 2", done2, cyc, reads);
    end
    got = {id_ok2, ts_ok2, timeout2, id_value2, ts_value2};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL lat2_result got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_reset_midseq();
    int cyc = 0;
    pulse_start();
    while (!(read && address) && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!(read && address)) begin
      failures++;
      $display("FAIL midseq_reach got read=%b addr=%b want 1 1", read, address);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value} !== '0) begin
      failures++;
      $display("FAIL midseq_async got=%h want=0", {read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value});
    end
    @(negedge clock) reset_n = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS});
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 2;
    while (!done && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!done || cyc != 4) begin
      failures++;
      $display("FAIL midseq_rerun got done=%0b cycles=%0d want 1 4", done, cyc);
    end
    repeat (3) @(negedge clock);
    got = {id_ok, ts_ok, timeout, id_value, ts_value};
    exp = exp_q.pop_front();
    checks++;
    if (!done || read || got !== exp) begin
      failures++;
      $display("FAIL midseq_result got done=%0b read=%0b res=%h want done=1 read=0 res=%h", done, read, got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_autorun();
    test_bad_id();
    test_stall();
    test_timeout();
    test_latency2();
    test_reset_midseq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
